// File: rtl/cpu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_sequencer
//
// Program sequencer that drives the 8-bit CPU core's external control input
// from a small loadable program store. A host writes up to DEPTH
// instructions while the sequencer is idle (or done), then pulses start_i.
// The sequencer issues control words, waits, and branches on the CPU status
// flags until it reaches an END instruction or is halted.
//
// Instruction format (IW = WORD_W+4):
//   [IW-1:IW-2] op       00 ISSUE, 01 BRANCH, 10 WAIT, 11 END
//   [IW-3:IW-4] sel      flag index for BRANCH (C=0, Z=1, V=2, N=3)
//   [WORD_W-1:0] payload control word / branch target / wait count
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   load_valid_i/_data_i   program write request and instruction
//   load_ready_o           write accepted when valid && ready (IDLE/DONE only)
//   start_i, halt_i        begin execution at pc 0 / abort execution
//   step_mode_i, step_i    single-step controls (only with SEQ_SINGLE_STEP_EN)
//   flags_i                CPU status {N,V,Z,C}
//   ctrl_o, ctrl_valid_o   control word and its one-cycle update pulse
//   pc_o                   current program counter
//   busy_o, done_o         high in RUN/WAIT, high in DONE
//
// Build option:
//   SEQ_SINGLE_STEP_EN  when defined, step_mode_i=1 makes RUN and the WAIT
//                       countdown advance only on edges where step_i=1.
//                       When undefined, step_mode_i and step_i are ignored.
// ---------------------------------------------------------------------------
module cpu_ctrl_sequencer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_valid_i,
  input  logic [WORD_W+3:0] load_data_i,
  output logic              load_ready_o,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              step_mode_i,
  input  logic              step_i,
  input  logic [3:0]        flags_i,
  output logic [WORD_W-1:0] ctrl_o,
  output logic              ctrl_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IW = WORD_W + 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ISSUE  = 2'b00,
    OP_BRANCH = 2'b01,
    OP_WAIT   = 2'b10,
    OP_END    = 2'b11
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] ctrl_q, ctrl_d;
  logic              ctrl_valid_q, ctrl_valid_d;

  logic [IW-1:0]     mem_q [DEPTH];
  logic              mem_we;

  logic [IW-1:0]     instr;
  op_e               op;
  logic [1:0]        sel;
  logic [WORD_W-1:0] payload;
  logic              step_en;
  logic              load_ready;

  // Instruction fetch is a plain asynchronous read at the current pc, so the
  // instruction at pc executes on the very edge after pc is set.
  assign instr   = mem_q[pc_q];
  assign op      = op_e'(instr[IW-1:IW-2]);
  assign sel     = instr[IW-3:IW-4];
  assign payload = instr[WORD_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign step_en = !step_mode_i || step_i;
`else
  // Step controls are pin-compatible placeholders in this build.
  logic unused_step;
  assign unused_step = step_mode_i ^ step_i;
  assign step_en     = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
    end
  end

  // NOTE: the program store is reset on purpose: every entry becomes all-ones
  // (END), so starting an unloaded program terminates at once. This keeps it
  // in flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '1;
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= load_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_valid_i) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        // A write on the same edge still lands; the run reads it on the
        // following edge. Halt takes priority over start.
        if (start_i && !halt_i) begin
          pc_d     = '0;
          wr_ptr_d = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (halt_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (step_en) begin
          unique case (op)
            OP_ISSUE: begin
              ctrl_d       = payload;
              ctrl_valid_d = 1'b1;
              pc_d         = pc_q + ADDR_W'(1);
            end
            OP_BRANCH: begin
              pc_d = flags_i[sel] ? payload[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            end
            OP_WAIT: begin
              if (payload == '0) begin
                pc_d = pc_q + ADDR_W'(1);
              end else begin
                cnt_d   = payload;
                state_d = S_WAIT;
              end
            end
            OP_END: begin
              state_d = S_DONE;
            end
            default: ;
          endcase
        end
      end

      S_WAIT: begin
        if (halt_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (step_en) begin
          // The last wait cycle advances pc so the next instruction runs on
          // the following edge: 1 + n edges in total for WAIT n.
          if (cnt_q == WORD_W'(1)) begin
            cnt_d   = '0;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - WORD_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    busy_o     = (state_q == S_RUN)  || (state_q == S_WAIT);
    done_o     = (state_q == S_DONE);
  end

  assign load_ready_o = load_ready;
  assign ctrl_o       = ctrl_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for cpu_ctrl_sequencer. A behavioural model interprets the program
// store as a list of instructions and produces, per execute edge, whether a
// control word is issued and its value, plus the edge at which END runs.
// Directed programs are followed by randomized programs and flags.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_sequencer;

  localparam int LIM = 48;  // execute edges observed per run

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        load_valid_i = 1'b0;
  logic [11:0] load_data_i = '0;
  logic        load_ready_o;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        step_mode_i = 1'b0;
  logic        step_i = 1'b0;
  logic [3:0]  flags_i = '0;
  logic [7:0]  ctrl_o;
  logic        ctrl_valid_o;
  logic [3:0]  pc_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  cpu_ctrl_sequencer #(.WORD_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .start_i      (start_i),
    .halt_i       (halt_i),
    .step_mode_i  (step_mode_i),
    .step_i       (step_i),
    .flags_i      (flags_i),
    .ctrl_o       (ctrl_o),
    .ctrl_valid_o (ctrl_valid_o),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [11:0] model_mem [16];
  int          model_wr;
  logic [7:0]  ctrl_hold;
  bit          m_vld  [LIM+1];
  logic [7:0]  m_iss  [LIM+1];
  logic [7:0]  m_ctrl [LIM+1];
  int          m_end;
  int          m_pc_final;

  logic [11:0] prog [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 12'hFFF;
    model_wr  = 0;
    ctrl_hold = 8'h00;
  endtask

  // Walk the program: t is the execute edge number (1 = first edge after the
  // start edge). ISSUE/BRANCH take one edge, WAIT n takes 1+n, END stops.
  task automatic model_run(input logic [3:0] flags);
    int         t;
    int         pc;
    logic [11:0] w;
    logic [7:0] pay;
    logic [7:0] cur;
    t  = 1;
    pc = 0;
    m_end = 0;
    for (int k = 0; k <= LIM; k++) begin
      m_vld[k] = 1'b0;
      m_iss[k] = 8'h00;
    end
    while (t <= LIM && m_end == 0) begin
      w   = model_mem[pc];
      pay = w[7:0];
      case (w[11:10])
        2'd0: begin m_vld[t] = 1'b1; m_iss[t] = pay; t++; pc = (pc + 1) % 16; end
        2'd1: begin pc = flags[w[9:8]] ? int'(pay[3:0]) : (pc + 1) % 16; t++; end
        2'd2: begin t += 1 + int'(pay); pc = (pc + 1) % 16; end
        default: m_end = t;
      endcase
    end
    m_pc_final = pc;
    cur = ctrl_hold;
    m_ctrl[0] = cur;
    for (int k = 1; k <= LIM; k++) begin
      if (m_vld[k]) cur = m_iss[k];
      m_ctrl[k] = cur;
    end
  endtask

  task automatic load_prog(input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s.ready%0d", tag, i), load_ready_o, 1);
      load_valid_i = 1'b1;
      load_data_i  = prog[i];
      model_mem[model_wr] = prog[i];
      model_wr = (model_wr + 1) % 16;
      @(negedge clk);
    end
    load_valid_i = 1'b0;
  endtask

  // Start (optionally with a same-edge write), follow the run edge by edge,
  // and halt if the program has not ended inside the observation window.
  task automatic run_prog(input logic [3:0] flags, input bit wr_en,
                          input logic [11:0] wr_word, input string tag);
    int last;
    flags_i = flags;
    start_i = 1'b1;
    if (wr_en) begin
      load_valid_i = 1'b1;
      load_data_i  = wr_word;
      model_mem[model_wr] = wr_word;
    end
    model_wr = 0;
    model_run(flags);
    @(negedge clk);
    start_i      = 1'b0;
    load_valid_i = 1'b0;
    check({tag, ".e0.busy"}, busy_o, 1);
    check({tag, ".e0.vld"},  ctrl_valid_o, 0);
    check({tag, ".e0.pc"},   pc_o, 0);
    last = (m_end > 0) ? m_end : LIM;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("%s.e%0d.vld", tag, k),  ctrl_valid_o, m_vld[k]);
      check($sformatf("%s.e%0d.ctrl", tag, k), ctrl_o, m_ctrl[k]);
      check($sformatf("%s.e%0d.busy", tag, k), busy_o, (m_end == 0 || k < m_end));
      check($sformatf("%s.e%0d.done", tag, k), done_o, (m_end > 0 && k >= m_end));
      check($sformatf("%s.e%0d.rdy", tag, k),  load_ready_o, (m_end > 0 && k >= m_end));
    end
    if (m_end > 0) begin
      check({tag, ".pc_final"}, pc_o, m_pc_final);
      ctrl_hold = m_ctrl[m_end];
    end else begin
      halt_i = 1'b1;
      @(negedge clk);
      halt_i = 1'b0;
      check({tag, ".halt.busy"}, busy_o, 0);
      check({tag, ".halt.done"}, done_o, 0);
      check({tag, ".halt.rdy"},  load_ready_o, 1);
      check({tag, ".halt.vld"},  ctrl_valid_o, 0);
      check({tag, ".halt.ctrl"}, ctrl_o, m_ctrl[LIM]);
      ctrl_hold = m_ctrl[LIM];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and its output values
    model_reset();
    #2 rst_ni = 1'b0;
    #1;
    check("rst.ctrl", ctrl_o, 0);
    check("rst.vld",  ctrl_valid_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.done", done_o, 0);
    check("rst.rdy",  load_ready_o, 1);
    check("rst.pc",   pc_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Two issues then END
    prog[0] = 12'h05A; prog[1] = 12'h0A5; prog[2] = 12'hFFF;
    load_prog(3, "iss");
    run_prog(4'h0, 1'b0, 12'h000, "iss");
    check("iss.pc2", pc_o, 2);

    // WAIT 3 then issue; step controls must have no effect in this build
    prog[0] = 12'h803; prog[1] = 12'h011; prog[2] = 12'hFFF;
    load_prog(3, "wait");
`ifndef SEQ_SINGLE_STEP_EN
    step_mode_i = 1'b1;
`endif
    run_prog(4'h0, 1'b0, 12'h000, "wait");
    step_mode_i = 1'b0;

    // Branch on Z taken / not taken, restarting from DONE
    prog[0] = 12'h503; prog[1] = 12'h001; prog[2] = 12'hFFF;
    prog[3] = 12'h002; prog[4] = 12'hFFF;
    load_prog(5, "br");
    run_prog(4'b0010, 1'b0, 12'h000, "br_taken");
    run_prog(4'b0000, 1'b0, 12'h000, "br_fall");

    // Halt and start together from DONE: halt wins
    halt_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    halt_i = 1'b0; start_i = 1'b0;
    check("hs.busy", busy_o, 0);
    check("hs.rdy",  load_ready_o, 1);

    // Endless loop on C, ended by halt
    prog[0] = 12'h007; prog[1] = 12'h400;
    load_prog(2, "loop");
    run_prog(4'b0001, 1'b0, 12'h000, "loop");

    // Asynchronous reset in the middle of WAIT 200
    prog[0] = 12'h8C8; prog[1] = 12'hFFF;
    load_prog(2, "rw");
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("rw.busy_before", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rw.ctrl", ctrl_o, 0);
    check("rw.vld",  ctrl_valid_o, 0);
    check("rw.busy", busy_o, 0);
    check("rw.done", done_o, 0);
    check("rw.rdy",  load_ready_o, 1);
    check("rw.pc",   pc_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk);

    // Unloaded program ends after one execute edge
    run_prog(4'h0, 1'b0, 12'h000, "empty");

    // Write to address 0 on the start edge is executed
    run_prog(4'h0, 1'b1, 12'h03C, "wrst");

`ifdef SEQ_SINGLE_STEP_EN
    prog[0] = 12'h033; prog[1] = 12'h044; prog[2] = 12'hFFF;
    load_prog(3, "step");
    step_mode_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("step.hold%0d.vld", i), ctrl_valid_o, 0);
      check($sformatf("step.hold%0d.busy", i), busy_o, 1);
    end
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    check("step.s1.vld", ctrl_valid_o, 1);
    check("step.s1.ctrl", ctrl_o, 8'h33);
    @(negedge clk);
    check("step.gap.vld", ctrl_valid_o, 0);
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    check("step.s2.vld", ctrl_valid_o, 1);
    check("step.s2.ctrl", ctrl_o, 8'h44);
    @(negedge clk);
    check("step.s3.done", done_o, 0);
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    check("step.s3.done", done_o, 1);
    check("step.s3.pc", pc_o, 2);
    step_mode_i = 1'b0;
    ctrl_hold = 8'h44;
`endif

    // Randomized programs and flags
    for (int it = 0; it < 16; it++) begin
      int len;
      int r;
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4)      prog[i] = {4'b0000, 8'($urandom)};
        else if (r < 6) prog[i] = {2'b01, 2'($urandom), 8'($urandom)};
        else if (r < 8) prog[i] = {4'b1000, 8'($urandom_range(0, 4))};
        else            prog[i] = {2'b11, 10'($urandom)};
      end
      load_prog(len, $sformatf("rnd%0d", it));
      run_prog(4'($urandom), 1'b0, 12'h000, $sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
